// File: rtl/instruction_fetch_q_pkg.sv
// Shared definitions for the instruction fetch unit: redirect mode encoding and fetch step.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruction_fetch_q_pkg;

    // Next-PC selection carried on redirect_mode.
    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_mode_t;

    // Byte distance between consecutive instruction words.
    localparam int PC_STEP = 4;

    // A redirect only takes effect for a non-sequential mode.
    function automatic logic redirect_taken(input logic valid, input logic [1:0] mode);
        return valid && (npc_mode_t'(mode) != NPC_SEQ);
    endfunction

endpackage

// File: rtl/instruction_fetch_q_fetch_queue.sv
// Synchronous FIFO holding {pc, instruction} entries between fetch and decode.
// Latency: a push is visible at the head on the next cycle; flush empties it in one cycle.
// Backpressure: push ignored when full, pop ignored when empty; flush overrides both.
// Ports: clk/rst (async active-high), push/push_data, pop, flush, head, full, empty, count.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instruction_fetch_q.sv
// Fetch unit: owns the fetch PC, issues one word request at a time and queues {pc, instr} for decode.
// Latency: memory latency (>=1) from request to queue push, plus one cycle to appear at the head.
// Backpressure: decode stalls via instr_ready; issue stops once queued + in-flight reaches QDEPTH.
// Ports: clk, start_up (async active-high reset); imem_req/imem_addr/imem_rvalid/imem_rdata to memory;
//        instr_valid/instr_ready/instruction/instr_pc to decode; redirect_* from execute.
module instruction_fetch_q
    import instruction_fetch_q_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0020),
    parameter int                QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              start_up,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_mode,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [25:0]       redirect_imm,
    input  logic [ADDR_W-1:0] redirect_reg
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int EW = ADDR_W + 32;
    // Region bits a jump keeps from pc+4; everything below bit 28 comes from the immediate.
    localparam logic [ADDR_W-1:0] JMP_KEEP_MASK = ~ADDR_W'(28'hFFF_FFFF);
    localparam logic [ADDR_W-1:0] WORD_MASK     = ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              busy;
    logic              drop;

    logic              redirect;
    logic              issue;
    logic              rsp;
    logic              push;
    logic              pop;
    logic              q_full;
    logic              q_empty;
    logic [CW-1:0]     count;
    logic [EW-1:0]     q_head;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jmp_low;
    logic [ADDR_W-1:0] target;

    // Mode 00 with redirect_valid is treated as no redirect at all: no flush and no issue bubble.
    assign redirect = redirect_taken(redirect_valid, redirect_mode);

    // ---------------- redirect target ----------------
    assign pc4     = redirect_pc + ADDR_W'(PC_STEP);
    assign br_off  = {{(ADDR_W-18){redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
    assign jmp_low = ADDR_W'({redirect_imm, 2'b00});

    always_comb begin
        target = fetch_pc;
        case (npc_mode_t'(redirect_mode))
            NPC_BRANCH: target = pc4 + br_off;
            NPC_JUMP:   target = (pc4 & JMP_KEEP_MASK) | jmp_low;
            NPC_JR:     target = redirect_reg & WORD_MASK;
            default:    target = fetch_pc;
        endcase
    end

    // ---------------- request issue ----------------
    // Occupancy counts the in-flight word so a returning response always has a free slot.
    // Only registered state feeds this, keeping instr_ready off the request path.
    assign issue = !start_up && !redirect && (!busy || imem_rvalid)
                   && ((count + CW'(busy)) < CW'(QDEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc & WORD_MASK;

    // Responses arriving with nothing outstanding are ignored.
    assign rsp  = busy && imem_rvalid;
    assign push = rsp && !drop && !redirect && !q_full;
    assign pop  = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge start_up) begin
        if (start_up) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            busy     <= 1'b0;
            drop     <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= target;
            // A response landing now is simply discarded; one still in flight must be dropped later.
            busy     <= busy && !imem_rvalid;
            drop     <= busy && !imem_rvalid;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                req_pc   <= fetch_pc;
                busy     <= 1'b1;
            end else if (rsp) begin
                busy     <= 1'b0;
            end
            if (rsp) begin
                drop     <= 1'b0;
            end
        end
    end

    // ---------------- decode queue ----------------
    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (start_up),
        .push      (push),
        .push_data ({req_pc, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (count)
    );

    assign instr_valid = !q_empty;
    assign instr_pc    = q_head[EW-1:32];
    assign instruction = q_head[31:0];

endmodule

// File: tb/tb_instruction_fetch_q.sv
module tb_instruction_fetch_q;

    localparam int          AW  = 32;
    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0040_0020;

    logic        clk = 1'b0;
    logic        start_up;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [1:0]  redirect_mode;
    logic [31:0] redirect_pc;
    logic [25:0] redirect_imm;
    logic [31:0] redirect_reg;

    instruction_fetch_q #(
        .ADDR_W   (AW),
        .RESET_PC (RPC),
        .QDEPTH   (QD)
    ) dut (
        .clk            (clk),
        .start_up       (start_up),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_mode  (redirect_mode),
        .redirect_pc    (redirect_pc),
        .redirect_imm   (redirect_imm),
        .redirect_reg   (redirect_reg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Redirect target from the ISA rules, in plain arithmetic.
    function automatic logic [31:0] tgt(input logic [1:0] m, input logic [31:0] pc,
                                        input logic [25:0] imm, input logic [31:0] r);
        logic [31:0] pc4;
        int          off;
        pc4 = pc + 32'd4;
        case (m)
            2'b01: begin
                off = int'($signed(imm[15:0])) * 4;
                return pc4 + 32'(off);
            end
            2'b10:   return (pc4 & 32'hF000_0000) + 32'(imm) * 32'd4;
            default: return r - (r % 32'd4);
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Scoreboard: entries decode is owed, in order.
    ent_t        exp_q[$];
    logic [31:0] exp_fetch;
    int          epoch;
    int          req_cnt = 0;
    int          n_pop   = 0;
    int          lat_mode = 1;   // 0 = random latency 1..3, else fixed

    // Memory model plus fetch-order model, one process.
    initial begin : mem_and_model
        bit          mem_pend;
        int          mem_cnt;
        int          mem_ep;
        int          rsp_ep;
        logic [31:0] mem_addr;
        logic [31:0] rsp_addr;
        logic        redir;
        mem_pend    = 0;
        mem_cnt     = 0;
        mem_ep      = 0;
        rsp_ep      = -1;
        mem_addr    = '0;
        rsp_addr    = '0;
        epoch       = 0;
        exp_fetch   = RPC;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            imem_rvalid = 1'b0;
            if (start_up) begin
                mem_pend = 0;
            end else if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_of(mem_addr);
                    rsp_addr    = mem_addr;
                    rsp_ep      = mem_ep;
                    mem_pend    = 0;
                end
            end
            @(negedge clk);
            #2;
            redir = redirect_valid && (redirect_mode != 2'b00);
            if (start_up) begin
                check("req_in_reset", imem_req, 0);
                check("valid_in_reset", instr_valid, 0);
                exp_q.delete();
                epoch++;
                exp_fetch   = RPC;
                mem_pend    = 0;
                imem_rvalid = 1'b0;
            end else begin
                if (redir) begin
                    check("req_on_redirect", imem_req, 0);
                    exp_q.delete();
                    epoch++;
                    exp_fetch = tgt(redirect_mode, redirect_pc, redirect_imm, redirect_reg);
                end else if (imem_rvalid && rsp_ep == epoch) begin
                    exp_q.push_back({rsp_addr, word_of(rsp_addr)});
                end
                if (imem_req) begin
                    check("one_outstanding", mem_pend, 0);
                    check("imem_addr", imem_addr, exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                    req_cnt++;
                    mem_pend = 1;
                    mem_addr = imem_addr;
                    mem_ep   = epoch;
                    mem_cnt  = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
                end
            end
        end
    end

    // Decode-side monitor.
    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            if (!start_up && instr_valid) begin
                if (exp_q.size() == 0) begin
                    check("valid_without_entry", instr_valid, 0);
                end else if (instr_ready && !(redirect_valid && redirect_mode != 2'b00)) begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e.pc);
                    check("instruction", instruction, e.ins);
                    n_pop++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_redirect(input logic [1:0] m, input logic [31:0] pc,
                               input logic [25:0] imm, input logic [31:0] r);
        redirect_valid = 1'b1;
        redirect_mode  = m;
        redirect_pc    = pc;
        redirect_imm   = imm;
        redirect_reg   = r;
        cyc(1);
        redirect_valid = 1'b0;
    endtask

    task automatic next_req_addr(input string name, input logic [31:0] want);
        bit seen;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (imem_req) begin
                seen = 1;
                check(name, imem_addr, want);
            end
            @(posedge clk);
            #1;
        end
        check({name, "_seen"}, seen, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          r0;
        logic [31:0] h_ins;
        start_up       = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_mode  = 2'b00;
        redirect_pc    = '0;
        redirect_imm   = '0;
        redirect_reg   = '0;
        cyc(3);
        check("rst_valid", instr_valid, 0);
        check("rst_req", imem_req, 0);

        // Sequential stream at latency 1.
        start_up    = 1'b0;
        instr_ready = 1'b1;
        next_req_addr("first_addr", RPC);
        r0 = req_cnt;
        cyc(20);
        check("throughput_20", req_cnt - r0, 20);

        // Reset mid-stream.
        start_up = 1'b1;
        cyc(2);
        start_up = 1'b0;
        next_req_addr("addr_after_reset", RPC);

        // Back-pressure from an empty queue.
        start_up    = 1'b1;
        instr_ready = 1'b0;
        cyc(2);
        start_up = 1'b0;
        r0 = req_cnt;
        cyc(20);
        check("bp_reqs", req_cnt - r0, QD);
        check("bp_req_idle", imem_req, 0);
        check("bp_valid", instr_valid, 1);
        check("bp_head_pc", instr_pc, RPC);
        h_ins = word_of(RPC);
        cyc(5);
        check("bp_head_ins", instruction, h_ins);
        instr_ready = 1'b1;
        r0 = req_cnt;
        cyc(10);
        check("bp_resume", (req_cnt - r0) >= 5, 1);

        // Branch while a latency-3 request is in flight.
        start_up = 1'b1;
        cyc(2);
        lat_mode = 3;
        start_up = 1'b0;
        next_req_addr("lat3_first", RPC);
        do_redirect(2'b01, 32'h0040_0030, 26'h000_FFFC, 32'h0);
        check("flush_empty", instr_valid, 0);
        next_req_addr("branch_target", 32'h0040_0024);
        check("drop_no_push", instr_valid, 0);
        lat_mode = 1;

        // Jump then jr.
        do_redirect(2'b10, 32'h0040_0040, 26'h010_0000, 32'h0);
        next_req_addr("jump_target", 32'h0040_0000);
        do_redirect(2'b11, 32'h0, 26'h0, 32'h1000_0007);
        next_req_addr("jr_target", 32'h1000_0004);

        // Address wrap.
        do_redirect(2'b11, 32'h0, 26'h0, 32'hFFFF_FFFF);
        next_req_addr("wrap_first", 32'hFFFF_FFFC);
        next_req_addr("wrap_second", 32'h0000_0000);

        // Redirect coincident with a response and a pop.
        cyc(5);
        #2;
        check("coincide_setup", imem_rvalid && instr_valid, 1);
        redirect_valid = 1'b1;
        redirect_mode  = 2'b01;
        redirect_pc    = 32'h0040_0100;
        redirect_imm   = 26'h000_0002;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("coincide_flush", instr_valid, 0);
        next_req_addr("coincide_target", 32'h0040_010C);

        // Random traffic.
        lat_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_mode  = 2'($urandom_range(0, 3));
                redirect_pc    = $urandom() & 32'hFFFF_FFFC;
                redirect_imm   = 26'($urandom());
                redirect_reg   = $urandom();
            end else begin
                redirect_valid = 1'b0;
            end
            start_up = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        start_up       = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        cyc(20);
        check("stream_alive", n_pop > 500, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
